// File: rtl/rvm_fetch_unit_if.sv
// Instruction-memory request/response bus: rvm_fetch_unit is the master, the memory is the slave.
interface rvm_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/rvm_fetch_unit.sv
// PC write-back and instruction fetch engine (IDLE/REQ/WAIT) with bus-error and timeout aborts.
// Optional alignment checking of fetch PC and redirect targets: define RVM_FETCH_ALIGN_CHECK_EN.
module rvm_fetch_unit #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  output logic             pc_w_en,
  output logic [31:0]      pc_wdata,
  input  logic             fetch_start,
  input  logic             pc_update,
  input  logic             pc_redirect,
  input  logic [31:0]      pc_target,
  output logic             fetch_done,
  output logic             fetch_error,
  output logic [1:0]       fetch_err_cause,
  output logic [31:0]      instr,
  output logic             busy,
  rvm_fetch_unit_if.master imem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] CAUSE_BUS      = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 8'd1;

  logic [1:0] state;
  logic [7:0] tmo_cnt;
  logic       resp_ok;
  logic       tmo_hit;
  logic       pc_misaligned;
  logic       tgt_misaligned;

`ifdef RVM_FETCH_ALIGN_CHECK_EN
  assign pc_misaligned  = (pc[1:0] != 2'b00);
  assign tgt_misaligned = pc_redirect && (pc_target[1:0] != 2'b00);
`else
  assign pc_misaligned  = 1'b0;
  assign tgt_misaligned = 1'b0;
`endif

  // A response counts in WAIT, or in REQ only when it arrives together with the grant.
  assign resp_ok = imem.imem_rvalid &&
                   ((state == S_WAIT) || ((state == S_REQ) && imem.imem_gnt));
  assign tmo_hit = (TIMEOUT_CYCLES != 8'd0) && (tmo_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      tmo_cnt         <= 8'd0;
      busy            <= 1'b0;
      pc_w_en         <= 1'b0;
      pc_wdata        <= 32'd0;
      fetch_done      <= 1'b0;
      fetch_error     <= 1'b0;
      fetch_err_cause <= CAUSE_BUS;
      instr           <= 32'd0;
      imem.imem_req   <= 1'b0;
      imem.imem_addr  <= 32'd0;
    end else begin
      // NOTE: non-blocking defaults here make every strobe a single-cycle pulse unless re-asserted below.
      pc_w_en     <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_error <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pc_update) begin
            pc_w_en  <= 1'b1;
            pc_wdata <= pc_redirect ? pc_target : pc + 32'd4;
            if (tgt_misaligned) begin
              fetch_error     <= 1'b1;
              fetch_err_cause <= CAUSE_MISALIGN;
            end
          end else if (fetch_start) begin
            if (pc_misaligned) begin
              fetch_error     <= 1'b1;
              fetch_err_cause <= CAUSE_MISALIGN;
            end else begin
              imem.imem_req  <= 1'b1;
              imem.imem_addr <= pc;
              tmo_cnt        <= 8'd0;
              busy           <= 1'b1;
              state          <= S_REQ;
            end
          end
        end

        S_REQ, S_WAIT: begin
          if (resp_ok) begin
            imem.imem_req <= 1'b0;
            busy          <= 1'b0;
            state         <= S_IDLE;
            if (imem.imem_err) begin
              fetch_error     <= 1'b1;
              fetch_err_cause <= CAUSE_BUS;
            end else begin
              instr      <= imem.imem_rdata;
              fetch_done <= 1'b1;
            end
          end else if (tmo_hit) begin
            imem.imem_req   <= 1'b0;
            busy            <= 1'b0;
            state           <= S_IDLE;
            fetch_error     <= 1'b1;
            fetch_err_cause <= CAUSE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if ((state == S_REQ) && imem.imem_gnt) begin
              imem.imem_req <= 1'b0;
              state         <= S_WAIT;
            end
          end
        end

        default: begin
          imem.imem_req <= 1'b0;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvm_fetch_unit.sv
// Self-checking bench: two fetch units (timeouts 10 and 4) share one stimulus stream and are
// checked cycle by cycle against a transaction-level model of each fetch/update.
module tb_rvm_fetch_unit;

  localparam logic [7:0] T_A = 8'd10;
  localparam logic [7:0] T_B = 8'd4;
`ifdef RVM_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] pc = 32'd0;
  logic [31:0] pc_target = 32'd0;
  logic        fetch_start = 1'b0;
  logic        pc_update = 1'b0;
  logic        pc_redirect = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic        err = 1'b0;
  logic [31:0] rdata = 32'd0;

  wire [1:0]  pc_w_en_v, fetch_done_v, fetch_error_v, busy_v;
  wire [31:0] pc_wdata_v [2];
  wire [1:0]  cause_v [2];
  wire [31:0] instr_v [2];
  wire [1:0]  req_v;
  wire [31:0] addr_v [2];

  rvm_fetch_unit_if bus_a ();
  rvm_fetch_unit_if bus_b ();

  assign bus_a.imem_gnt    = gnt;
  assign bus_a.imem_rvalid = rvalid;
  assign bus_a.imem_rdata  = rdata;
  assign bus_a.imem_err    = err;
  assign bus_b.imem_gnt    = gnt;
  assign bus_b.imem_rvalid = rvalid;
  assign bus_b.imem_rdata  = rdata;
  assign bus_b.imem_err    = err;
  assign req_v     = {bus_b.imem_req, bus_a.imem_req};
  assign addr_v[0] = bus_a.imem_addr;
  assign addr_v[1] = bus_b.imem_addr;

  rvm_fetch_unit #(.TIMEOUT_CYCLES(T_A)) dut_a (
    .clk(clk), .reset(reset), .pc(pc),
    .pc_w_en(pc_w_en_v[0]), .pc_wdata(pc_wdata_v[0]),
    .fetch_start(fetch_start), .pc_update(pc_update),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .fetch_done(fetch_done_v[0]), .fetch_error(fetch_error_v[0]),
    .fetch_err_cause(cause_v[0]), .instr(instr_v[0]), .busy(busy_v[0]),
    .imem(bus_a)
  );

  rvm_fetch_unit #(.TIMEOUT_CYCLES(T_B)) dut_b (
    .clk(clk), .reset(reset), .pc(pc),
    .pc_w_en(pc_w_en_v[1]), .pc_wdata(pc_wdata_v[1]),
    .fetch_start(fetch_start), .pc_update(pc_update),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .fetch_done(fetch_done_v[1]), .fetch_error(fetch_error_v[1]),
    .fetch_err_cause(cause_v[1]), .instr(instr_v[1]), .busy(busy_v[1]),
    .imem(bus_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] instr_exp [2];
  logic [1:0]  cause_exp [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s pc_w_en%0d", tag, i),  32'(pc_w_en_v[i]), 32'd0);
      check($sformatf("%s pc_wdata%0d", tag, i), pc_wdata_v[i], 32'd0);
      check($sformatf("%s done%0d", tag, i),     32'(fetch_done_v[i]), 32'd0);
      check($sformatf("%s error%0d", tag, i),    32'(fetch_error_v[i]), 32'd0);
      check($sformatf("%s cause%0d", tag, i),    32'(cause_v[i]), 32'd0);
      check($sformatf("%s instr%0d", tag, i),    instr_v[i], 32'd0);
      check($sformatf("%s busy%0d", tag, i),     32'(busy_v[i]), 32'd0);
      check($sformatf("%s req%0d", tag, i),      32'(req_v[i]), 32'd0);
      check($sformatf("%s addr%0d", tag, i),     addr_v[i], 32'd0);
    end
  endtask

  // One fetch: grant in REQ cycle g, response d cycles after the grant cycle (d=0: same cycle).
  // Model: response lands r=g+d cycles after the first REQ cycle; accepted if r < timeout,
  // otherwise the unit aborts after exactly `timeout` cycles in REQ+WAIT.
  task automatic do_fetch(input int g, input int d, input bit err_f,
                          input logic [31:0] data, input logic [31:0] pcv);
    int r, last, req_end;
    int t [2];
    int e [2];
    bit ok [2];
    t[0] = int'(T_A);
    t[1] = int'(T_B);
    r    = g + d;
    last = r + 2;
    for (int i = 0; i < 2; i++) begin
      ok[i] = (t[i] == 0) || (r < t[i]);
      e[i]  = ok[i] ? r + 2 : t[i] + 1;
      if (e[i] > last) last = e[i];
    end
    pc = pcv;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    pc = $urandom();
    for (int k = 1; k <= last; k++) begin
      for (int i = 0; i < 2; i++) begin
        req_end = (g + 2 < e[i]) ? g + 2 : e[i];
        check($sformatf("busy%0d@%0d", i, k),  32'(busy_v[i]), 32'(k < e[i]));
        check($sformatf("req%0d@%0d", i, k),   32'(req_v[i]), 32'(k < req_end));
        if (k < req_end) check($sformatf("addr%0d@%0d", i, k), addr_v[i], pcv);
        check($sformatf("done%0d@%0d", i, k),  32'(fetch_done_v[i]),
              32'((k == e[i]) && ok[i] && !err_f));
        check($sformatf("error%0d@%0d", i, k), 32'(fetch_error_v[i]),
              32'((k == e[i]) && !(ok[i] && !err_f)));
        check($sformatf("pcwen%0d@%0d", i, k), 32'(pc_w_en_v[i]), 32'd0);
      end
      gnt    = (k == g + 1);
      rvalid = (k == r + 1);
      if (rvalid) begin
        err   = err_f;
        rdata = data;
      end else begin
        err   = ($urandom_range(0, 1) != 0);
        rdata = $urandom();
      end
      step();
    end
    gnt    = 1'b0;
    rvalid = 1'b0;
    err    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ok[i] && !err_f) instr_exp[i] = data;
      else                 cause_exp[i] = ok[i] ? 2'd0 : 2'd1;
      check($sformatf("instr%0d after fetch", i), instr_v[i], instr_exp[i]);
      check($sformatf("cause%0d after fetch", i), 32'(cause_v[i]), 32'(cause_exp[i]));
    end
    step();
  endtask

  task automatic do_update(input logic [31:0] pcv, input bit redir,
                           input logic [31:0] tgt, input bit with_start);
    logic [31:0] exp_pc;
    bit          exp_err;
    exp_pc  = redir ? tgt : pcv + 32'd4;
    exp_err = ALIGN && redir && (tgt[1:0] != 2'b00);
    pc = pcv; pc_redirect = redir; pc_target = tgt;
    pc_update = 1'b1; fetch_start = with_start;
    step();
    pc_update = 1'b0; fetch_start = 1'b0; pc_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("upd pc_w_en%0d", i),  32'(pc_w_en_v[i]), 32'd1);
      check($sformatf("upd pc_wdata%0d", i), pc_wdata_v[i], exp_pc);
      check($sformatf("upd req%0d", i),      32'(req_v[i]), 32'd0);
      check($sformatf("upd busy%0d", i),     32'(busy_v[i]), 32'd0);
      check($sformatf("upd done%0d", i),     32'(fetch_done_v[i]), 32'd0);
      check($sformatf("upd error%0d", i),    32'(fetch_error_v[i]), 32'(exp_err));
      if (exp_err) cause_exp[i] = 2'd2;
      check($sformatf("upd cause%0d", i),    32'(cause_v[i]), 32'(cause_exp[i]));
    end
    step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("upd+1 pc_w_en%0d", i), 32'(pc_w_en_v[i]), 32'd0);
      check($sformatf("upd+1 req%0d", i),     32'(req_v[i]), 32'd0);
      check($sformatf("upd+1 busy%0d", i),    32'(busy_v[i]), 32'd0);
      check($sformatf("upd+1 error%0d", i),   32'(fetch_error_v[i]), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    v = $urandom();
    if (ALIGN) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    instr_exp[0] = 32'd0; instr_exp[1] = 32'd0;
    cause_exp[0] = 2'd0;  cause_exp[1] = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    check_zero("in reset");
    reset = 1'b0;
    step();
    check_zero("after reset");

    // Zero-wait memory: grant with the request, data one cycle later.
    do_fetch(0, 1, 1'b0, 32'h0050_0093, 32'h0000_0000);

    do_update(32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_update(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
    do_update(32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 1'b0);

    // Grant withheld 5 cycles, then an error response.
    do_fetch(5, 1, 1'b1, 32'hCAFE_F00D, 32'h0000_0300);

    // Never granted in time: both units time out, late grant/response land in IDLE.
    do_fetch(20, 0, 1'b0, 32'h1111_2222, 32'h0000_0400);

    // Simultaneous fetch_start and pc_update: the update wins.
    do_update(32'h0000_0400, 1'b0, 32'h0, 1'b1);

`ifdef RVM_FETCH_ALIGN_CHECK_EN
    pc = 32'h0000_0102;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cause_exp[i] = 2'd2;
      check($sformatf("mis req%0d", i),   32'(req_v[i]), 32'd0);
      check($sformatf("mis busy%0d", i),  32'(busy_v[i]), 32'd0);
      check($sformatf("mis error%0d", i), 32'(fetch_error_v[i]), 32'd1);
      check($sformatf("mis cause%0d", i), 32'(cause_v[i]), 32'd2);
    end
    step();
    for (int i = 0; i < 2; i++)
      check($sformatf("mis+1 error%0d", i), 32'(fetch_error_v[i]), 32'd0);
    do_update(32'h0, 1'b1, 32'h0000_0203, 1'b0);
`else
    do_fetch(0, 1, 1'b0, 32'h0000_0013, 32'h0000_0102);
`endif

    // Reset while both units wait for a response.
    pc = 32'h0000_0200;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("reset in WAIT");
    step();
    reset = 1'b0;
    instr_exp[0] = 32'd0; instr_exp[1] = 32'd0;
    cause_exp[0] = 2'd0;  cause_exp[1] = 2'd0;
    step();
    check_zero("after WAIT reset");
    do_fetch(1, 0, 1'b0, 32'h00A0_0513, 32'h0000_0204);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0)
        do_fetch($urandom_range(0, 6), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                 $urandom(), rand_pc());
      else
        do_update($urandom(), ($urandom_range(0, 1) != 0), $urandom(), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
